// File: rtl/peak_event_pkg.sv
// -----------------------------------------------------------------------------
// peak_event_pkg
//
// Shared constants, types and helper functions for the peak-event logger.
//
// Contents:
//   PE_N, PE_DEPTH, PE_TW  default sample width, FIFO depth, timestamp width
//   PE_HAS_DELTA           1 when PEAK_EVENT_DELTA_EN is defined
//   cnt_w(depth)           width of an occupancy counter that can hold 0..depth
//   rec_w(n, tw)           width of one packed event record
//   cmp_e                  outcome of comparing maximum against prev
//
// Record layout, MSB to LSB: value [N], time [TW], then delta [N] when
// PEAK_EVENT_DELTA_EN is defined.
//
// Configuration macro: PEAK_EVENT_DELTA_EN
// -----------------------------------------------------------------------------
package peak_event_pkg;

  localparam int PE_N     = 10;
  localparam int PE_DEPTH = 8;
  localparam int PE_TW    = 16;

`ifdef PEAK_EVENT_DELTA_EN
  localparam bit PE_HAS_DELTA = 1'b1;
`else
  localparam bit PE_HAS_DELTA = 1'b0;
`endif

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int rec_w(input int n, input int tw);
    return PE_HAS_DELTA ? (2 * n + tw) : (n + tw);
  endfunction

  typedef enum logic [1:0] {
    CMP_EQUAL = 2'd0,
    CMP_RISE  = 2'd1,
    CMP_FALL  = 2'd2
  } cmp_e;

endpackage

// File: rtl/peak_event_fifo_if.sv
// -----------------------------------------------------------------------------
// peak_event_fifo_if
//
// Valid/ready event stream carrying the head record of the peak-event FIFO.
//
// Signals:
//   evt_valid  head record presented (FIFO non-empty)
//   evt_ready  consumer accepts the head record
//   evt_value  peak value of the head record
//   evt_time   timestamp of the head record
//   evt_delta  rise amount of the head record (PEAK_EVENT_DELTA_EN only)
//
// Modports: master = event producer (the FIFO), slave = host consumer.
//
// Configuration macro: PEAK_EVENT_DELTA_EN
// -----------------------------------------------------------------------------
interface peak_event_fifo_if
  import peak_event_pkg::*;
#(
  parameter int N  = PE_N,
  parameter int TW = PE_TW
);

  logic          evt_valid;
  logic          evt_ready;
  logic [N-1:0]  evt_value;
  logic [TW-1:0] evt_time;
`ifdef PEAK_EVENT_DELTA_EN
  logic [N-1:0]  evt_delta;
`endif

  modport master (
    output evt_valid,
    output evt_value,
    output evt_time,
`ifdef PEAK_EVENT_DELTA_EN
    output evt_delta,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_value,
    input  evt_time,
`ifdef PEAK_EVENT_DELTA_EN
    input  evt_delta,
`endif
    output evt_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with a registered head word. The head register always
// holds the oldest entry (or zero when empty), so the read data is stable
// while the consumer stalls and there is no same-cycle fall-through.
//
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is ignored and the caller decides what to do with it.
//
// Ports:
//   clock, reset  single clock, synchronous active-high reset
//   push, din     write request and data
//   pop           read request (ignored while empty)
//   dout          registered head word
//   full, empty   occupancy flags (count == DEPTH / count == 0)
//   count         entries currently held
// -----------------------------------------------------------------------------
module sync_fifo
  import peak_event_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = head;

  // A full FIFO still takes a write when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  assign rd_next = rd_ptr + AW'(1);

  // Next head word: the entry behind the current head on a pop, the incoming
  // word when it becomes the only entry, otherwise unchanged.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    head_d = head;
    if (do_pop) begin
      if (cnt > CW'(1)) begin
        head_d = mem[rd_next];
      end else if (do_push) begin
        head_d = din;
      end else begin
        head_d = '0;
      end
    end else if (do_push && empty) begin
      head_d = din;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every always_ff sees
    // the pre-edge value of every other register, independent of order.
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      head <= head_d;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/peak_event_fifo.sv
// -----------------------------------------------------------------------------
// peak_event_fifo
//
// Watches the running maximum from the upstream tracker and logs every new,
// larger peak as a {value, timestamp} record in a small FIFO read by a host
// over a valid/ready handshake. Events that arrive while the FIFO is full
// (and nothing leaves in that cycle) are dropped and latch the sticky
// overflow flag.
//
// Ports:
//   clock           single clock, all logic on posedge
//   reset           synchronous, active-high reset
//   maximum         running maximum from the upstream tracker
//   clear_overflow  clears overflow (a same-cycle drop wins)
//   count           entries currently held
//   overflow        sticky: at least one event was dropped
//   evt             event stream (master side of peak_event_fifo_if)
//
// Configuration macro: PEAK_EVENT_DELTA_EN adds evt_delta = maximum - prev
// at detection time, stored per record.
// -----------------------------------------------------------------------------
module peak_event_fifo
  import peak_event_pkg::*;
#(
  parameter int N     = PE_N,
  parameter int DEPTH = PE_DEPTH,
  parameter int TW    = PE_TW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             maximum,
  input  logic                     clear_overflow,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  peak_event_fifo_if.master        evt
);

  localparam int RW = rec_w(N, TW);

  logic [TW-1:0] ts;
  logic [N-1:0]  prev;
  cmp_e          cmp;
  logic          push;
  logic          drop;
  logic          full;
  logic          empty;
  logic [RW-1:0] rec_in;
  logic [RW-1:0] rec_out;

  always_comb begin
    cmp = CMP_EQUAL;
    if (maximum > prev) begin
      cmp = CMP_RISE;
    end else if (maximum < prev) begin
      cmp = CMP_FALL;
    end
  end

  assign push = (cmp == CMP_RISE);

  // A full FIFO only loses the event when the head is not leaving this cycle.
  assign drop = push && full && !evt.evt_ready;

`ifdef PEAK_EVENT_DELTA_EN
  assign rec_in = {maximum, ts, maximum - prev};
`else
  assign rec_in = {maximum, ts};
`endif

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (rec_in),
    .pop   (evt.evt_ready),
    .dout  (rec_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign evt.evt_valid = !empty;
  assign evt.evt_value = rec_out[RW-1 -: N];
  assign evt.evt_time  = rec_out[RW-N-1 -: TW];
`ifdef PEAK_EVENT_DELTA_EN
  assign evt.evt_delta = rec_out[N-1:0];
`endif

  // prev follows maximum on any change, including a fall (upstream restart)
  // and a dropped event, so a level is never reported twice.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts       <= '0;
      prev     <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + TW'(1);
      if (cmp != CMP_EQUAL) begin
        prev <= maximum;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/peak_event_fifo.md
# peak_event_fifo

Downstream consumer of the running-maximum tracker. Samples the tracker's `maximum` output every clock and detects each time a new, larger peak appears. Each new peak is logged as an event record (value and timestamp) in a small FIFO, which a slower host reads over a valid/ready handshake. Events are dropped when the FIFO is full, and a sticky overflow flag records the loss.

## Interface
- `N`, 10, sample/maximum width; must match the upstream tracker
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `TW`, 16, timestamp width
- `clock`  input  1  single clock; all logic on posedge
- `reset`  input  1  synchronous, active-high reset
- `maximum`  input  N  running maximum from the upstream tracker
- `evt_ready`  input  1  consumer accepts head record
- `clear_overflow`  input  1  clears `overflow`
- `evt_valid`  output  1  FIFO non-empty; head record presented
- `evt_value`  output  N  peak value of head record
- `evt_time`  output  TW  timestamp of head record
- `count`  output  $clog2(DEPTH+1)  entries currently held
- `overflow`  output  1  sticky; at least one event was dropped

## Operation
- Timestamp counter `ts`:
  - 0 out of reset; +1 every clock.
  - Wraps from 2^TW−1 to 0 with no flag.
- Reference register `prev`: 0 out of reset; compared against `maximum` every clock.
  - `maximum > prev`: new-peak event; `prev <= maximum`; push {`maximum`, `ts`}.
  - `maximum < prev`: upstream was reset; `prev <= maximum`; no event.
  - `maximum == prev`: no action.
- Pop: `evt_valid && evt_ready` at a posedge.
- Push when not full: accepted.
- Push when full:
  - Without a pop in the same cycle: event discarded; `overflow <= 1`.
  - With a pop in the same cycle: push accepted; `count` unchanged.
- Push and pop in the same cycle, non-full: both occur; `count` unchanged.
- `overflow` clearing:
  - `clear_overflow` clears it.
  - A drop in the same cycle as `clear_overflow`: set wins.
- `prev` always updates even when the event is dropped, so no duplicate event is generated later.
- While `evt_valid && !evt_ready`, `evt_value`/`evt_time` are held stable.

## Timing
- Reset (synchronous, any cycle, including mid-operation):
  - `ts`, `prev`, read/write pointers, `count`, `overflow` ← 0.
  - `evt_valid` = 0; `evt_value`/`evt_time` = 0.
  - All FIFO contents are discarded.
- Event latency:
  - A `maximum` rise sampled at edge k gives `evt_valid` high after edge k (cycle k+1) if the FIFO was empty.
  - There is no same-cycle fall-through.
- The recorded `evt_time` is the `ts` value in the cycle before edge k, i.e. the value being sampled at edge k.
- `count` and `evt_valid` update at the same edge as the push/pop that changes them.
- Full is `count == DEPTH`; empty is `count == 0`.
- Pointers wrap modulo DEPTH.

## Configuration
- `PEAK_EVENT_DELTA_EN` defined:
  - Adds output `evt_delta` [N-1:0] = `maximum − prev` at detection time, stored per entry alongside value/time.
  - Always > 0 for valid records.
  - Reset value 0.
- Macro undefined:
  - Port absent; FIFO word is N+TW bits.
  - All other behaviour is identical.

## Structure
- Package `peak_event_pkg`:
  - Default constants `PE_N = 10`, `PE_DEPTH = 8`, `PE_TW = 16`.
  - Function `cnt_w(depth)` returning $clog2(depth+1).
  - Record field order constant: value MSBs, then time, then optional delta.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push/pop/full/empty/count, registered head.
  - Contains the simultaneous push/pop-on-full rule.
- Top level holds `ts`, `prev`, the compare, record packing and `overflow`.

## Test plan
- **Single peak:** reset 2 cycles; `maximum` = 0 then 37 from cycle 5.
  - Exactly one record {37, 5}.
  - `evt_valid` high from cycle 6 until popped.
  - Delta build: `evt_delta` = 37.
- **Monotonic stream:** `maximum` 10, 10, 20, 20, 30 with `evt_ready` = 1.
  - Records 10, 20, 30 in order; `count` never exceeds 1.
  - No records for repeated values.
- **Overflow:** `evt_ready` = 0; 9 distinct rising peaks 1..9 with DEPTH = 8.
  - `count` = 8; `overflow` = 1.
  - Draining yields 1..8.
  - `clear_overflow` pulse returns `overflow` to 0.
- **Full + simultaneous pop:** FIFO full, `evt_ready` = 1, new peak 500 in the same cycle.
  - `count` stays 8; `overflow` stays 0.
  - 500 appears last when drained.
- **Upstream reset:** peaks to 900, `maximum` drops to 0, then 50.
  - Records 900 and 50; no record for the drop.
- **Reset mid-operation:** 3 records queued, `reset` = 1 for one cycle.
  - All outputs 0 the next cycle; `ts` restarts at 0.
  - Held `maximum` = 900 produces a new record {900, 0}.
